motor_monitor: RTL and testbench
================================

Name: motor_monitor

Overview:
- Receiver side of the two-cylinder 4-stroke engine state interface: consumes one-hot stroke codes for cylinders 1 and 2.
- Checks stroke-sequence legality and the 2-stroke phase offset between cylinders.
- Counts ignitions, measures the ignition-to-ignition period in clocks, and derives a windowed RPM estimate.
- Sits downstream of the engine state generator, feeding display and diagnostics.

Parameters:
- LOCK_COUNT, 4: consecutive legal samples required to declare lock.
- WINDOW_CYCLES, 1000: clock cycles per RPM measurement window.
- RPM_PER_IGN, 6: RPM contribution per ignition counted in one window.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sample_en  in  1  when 1, cil1/cil2 are sampled this cycle.
- cil1  in  4  cylinder 1 stroke: 1000 ADM, 0100 COMP, 0010 IGN, 0001 EXA.
- cil2  in  4  cylinder 2 stroke, same encoding.
- clr_err  in  1  clears sticky error flags and err_count.
- locked  out  1  FSM in TRACK.
- ign_pulse  out  1  one-cycle pulse per sample containing a legal ignition entry.
- ign_count  out  16  total legal ignitions, saturating at 65535.
- period_cycles  out  16  clocks between the last two ignition samples, saturating.
- period_valid  out  1  one-cycle pulse when period_cycles updates.
- rpm_est  out  13  windowed RPM estimate, saturating at 8191.
- seq_err1  out  1  sticky: illegal cylinder 1 transition or non-one-hot code.
- seq_err2  out  1  sticky: same check for cylinder 2.
- phase_err  out  1  sticky: phase relation violated.
- err_count  out  8  error samples in TRACK, saturating at 255.

Behaviour:
- Reset (synchronous, high) clears every output to 0, puts the FSM in SEARCH, and clears all internal counters and the stored previous sample.
- Reset asserted mid-operation takes priority over everything, including clr_err and sample_en.
- All outputs are registered. Any effect of a sample is visible the cycle after the clk edge where sample_en=1.
- Legal successor is a rotate right by 1: 1000→0100→0010→0001→1000.
- A sample is rejected if either code is not one-hot, or if it repeats the previous value.
- Phase rule: cil2 == {cil1[1:0], cil1[3:2]}. Legal pairs are ADM/IGN, COMP/EXA, IGN/ADM, EXA/COMP.
- A sample is "good" when both transitions are legal and the phase rule holds.
- FSM SEARCH:
  - First sample after entry is stored only; good-count = 0.
  - Each good sample increments good-count; any bad sample resets it to 0 and is stored as the new previous.
  - When good-count reaches LOCK_COUNT, go to TRACK and set locked=1.
  - No errors are flagged in SEARCH.
- FSM TRACK:
  - On a bad sample: set the relevant sticky flags (seq_err1, seq_err2, phase_err independently), increment err_count, drop locked, and go to FAULT.
- FSM FAULT: lasts exactly one cycle, then SEARCH with the stored-sample slot empty.
- Ignition detection:
  - Only in TRACK, on a good sample where a cylinder enters 0010 from 0100.
  - ign_pulse=1 for one cycle.
  - ign_count += number of cylinders igniting (0, 1 or 2), saturating.
- Period measurement:
  - A free-running 16-bit counter, saturating at 65535, restarts at 1 on each ignition sample.
  - On every ignition sample after the first since entering TRACK, period_cycles <= counter value and period_valid=1.
  - Leaving TRACK re-arms "first".
- RPM window:
  - A window counter runs from 0 to WINDOW_CYCLES-1 continuously, independent of FSM state.
  - On the terminal cycle: rpm_est <= min(win_ign*RPM_PER_IGN, 8191), then win_ign <= 0.
  - An ignition on the terminal cycle counts toward the next window.
  - win_ign increments only in TRACK.
- clr_err=1: seq_err1/seq_err2/phase_err/err_count <= 0 next cycle. A simultaneous new error wins, leaving the flag set and err_count=1.
- Non-sample cycles (sample_en=0): no sequence checks, FSM holds. Period and window counters keep running.

Test Plan:
- Reset held 3 cycles while inputs toggle → all outputs 0, locked=0; after release with no sample_en, nothing changes except internal counters.
- Legal sequence, sample_en=1 every cycle, cil1 starting 1000 / cil2 0010, LOCK_COUNT=4 → locked=1 visible after 5th sample edge; ign_pulse every 2 cycles; period_cycles=2.
- Same stimulus for 2 full windows of 1000 cycles → 500 ignitions/window, rpm_est=3000 after each window terminal.
- In TRACK, cil1 jumps 0100→0001 → seq_err1=1, err_count=1, locked=0; relock after LOCK_COUNT+1 good samples; seq_err1 stays 1 until clr_err.
- In TRACK, cil2 forced equal to cil1 (1000/1000) → phase_err=1, seq_err2=1, err_count=1. A non-one-hot 0110 on cil2 in SEARCH → no flag set.
- RPM_PER_IGN=20 with 500 ignitions/window → rpm_est saturates at 8191. Reset asserted mid-window → rpm_est=0, FSM SEARCH next cycle.

Source files
------------

// File: rtl/motor_monitor_if.sv
// rtl/motor_monitor_if.sv - engine state link between the stroke generator and motor_monitor
// master drives cylinder codes and clear; slave (the monitor) returns status and measurements.
interface motor_monitor_if;
    logic        sample_en;
    logic [3:0]  cil1;
    logic [3:0]  cil2;
    logic        clr_err;
    logic        locked;
    logic        ign_pulse;
    logic [15:0] ign_count;
    logic [15:0] period_cycles;
    logic        period_valid;
    logic [12:0] rpm_est;
    logic        seq_err1;
    logic        seq_err2;
    logic        phase_err;
    logic [7:0]  err_count;

    modport master (
        output sample_en, cil1, cil2, clr_err,
        input  locked, ign_pulse, ign_count, period_cycles, period_valid,
               rpm_est, seq_err1, seq_err2, phase_err, err_count
    );

    modport slave (
        input  sample_en, cil1, cil2, clr_err,
        output locked, ign_pulse, ign_count, period_cycles, period_valid,
               rpm_est, seq_err1, seq_err2, phase_err, err_count
    );
endinterface

// File: rtl/motor_monitor.sv
// rtl/motor_monitor.sv - two-cylinder 4-stroke sequence checker, ignition counter and RPM estimator
// Locks onto a legal stroke stream, flags sticky errors while tracking, measures period and windowed RPM.
module motor_monitor #(
    parameter int LOCK_COUNT    = 4,
    parameter int WINDOW_CYCLES = 1000,
    parameter int RPM_PER_IGN   = 6
) (
    input  logic            clk,
    input  logic            reset,
    motor_monitor_if.slave  bus
);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int WW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

    typedef enum logic [1:0] {SEARCH, TRACK, FAULT} state_e;

    state_e       state_q;
    logic [3:0]   prev1_q, prev2_q;
    logic         prev_valid_q;
    logic [GW-1:0] good_cnt_q;
    logic         have_ign_q;
    logic [15:0]  per_cnt_q, per_cnt_d;
    logic [WW-1:0] win_cnt_q;
    logic [15:0]  win_ign_q, win_ign_d;

    logic         locked_q, ign_pulse_q, period_valid_q;
    logic [15:0]  ign_count_q, ign_count_d, period_q;
    logic [12:0]  rpm_q, rpm_d;
    logic         seq_err1_q, seq_err1_d, seq_err2_q, seq_err2_d, phase_err_q, phase_err_d;
    logic [7:0]   err_count_q, err_count_d;

    logic         legal1, legal2, phase_ok, good, track_sample, trk_err;
    logic         ign1, ign2, ign_any, win_term;
    logic [1:0]   ign_n;
    logic [16:0]  ign_sum, win_sum;
    logic [31:0]  rpm_prod;
    logic [7:0]   err_base;

    // Legal successor is a rotate right; a repeated or non-one-hot code can never match it.
    always_comb begin
        legal1       = prev_valid_q && $onehot(bus.cil1) && (bus.cil1 == {prev1_q[0], prev1_q[3:1]});
        legal2       = prev_valid_q && $onehot(bus.cil2) && (bus.cil2 == {prev2_q[0], prev2_q[3:1]});
        phase_ok     = (bus.cil2 == {bus.cil1[1:0], bus.cil1[3:2]});
        good         = legal1 && legal2 && phase_ok;
        track_sample = bus.sample_en && (state_q == TRACK);
        trk_err      = track_sample && !good;
        ign1         = track_sample && good && (prev1_q == 4'b0100) && (bus.cil1 == 4'b0010);
        ign2         = track_sample && good && (prev2_q == 4'b0100) && (bus.cil2 == 4'b0010);
        ign_any      = ign1 || ign2;
        ign_n        = {1'b0, ign1} + {1'b0, ign2};
    end

    always_comb begin
        ign_sum     = {1'b0, ign_count_q} + 17'(ign_n);
        ign_count_d = ign_sum[16] ? 16'hFFFF : ign_sum[15:0];

        if (ign_any)
            per_cnt_d = 16'd1;
        else if (per_cnt_q == 16'hFFFF)
            per_cnt_d = per_cnt_q;
        else
            per_cnt_d = per_cnt_q + 16'd1;

        // An ignition landing on the terminal cycle seeds the next window.
        win_term  = (win_cnt_q == WW'(WINDOW_CYCLES - 1));
        win_sum   = {1'b0, win_ign_q} + 17'(ign_n);
        if (win_term)
            win_ign_d = 16'(ign_n);
        else
            win_ign_d = win_sum[16] ? 16'hFFFF : win_sum[15:0];

        rpm_prod = 32'(win_ign_q) * 32'(RPM_PER_IGN);
        rpm_d    = (rpm_prod > 32'd8191) ? 13'h1FFF : rpm_prod[12:0];

        // A new error in the same cycle as clr_err survives the clear.
        err_base    = bus.clr_err ? 8'd0 : err_count_q;
        err_count_d = err_base;
        if (trk_err && err_base != 8'hFF)
            err_count_d = err_base + 8'd1;
        seq_err1_d  = (!bus.clr_err && seq_err1_q)  || (trk_err && !legal1);
        seq_err2_d  = (!bus.clr_err && seq_err2_q)  || (trk_err && !legal2);
        phase_err_d = (!bus.clr_err && phase_err_q) || (trk_err && !phase_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= SEARCH;
            prev1_q        <= 4'd0;
            prev2_q        <= 4'd0;
            prev_valid_q   <= 1'b0;
            good_cnt_q     <= '0;
            have_ign_q     <= 1'b0;
            per_cnt_q      <= 16'd0;
            win_cnt_q      <= '0;
            win_ign_q      <= 16'd0;
            locked_q       <= 1'b0;
            ign_pulse_q    <= 1'b0;
            period_valid_q <= 1'b0;
            ign_count_q    <= 16'd0;
            period_q       <= 16'd0;
            rpm_q          <= 13'd0;
            seq_err1_q     <= 1'b0;
            seq_err2_q     <= 1'b0;
            phase_err_q    <= 1'b0;
            err_count_q    <= 8'd0;
        end else begin
            ign_pulse_q    <= ign_any;
            ign_count_q    <= ign_count_d;
            per_cnt_q      <= per_cnt_d;
            win_ign_q      <= win_ign_d;
            win_cnt_q      <= win_term ? '0 : win_cnt_q + 1'b1;
            seq_err1_q     <= seq_err1_d;
            seq_err2_q     <= seq_err2_d;
            phase_err_q    <= phase_err_d;
            err_count_q    <= err_count_d;
            period_valid_q <= 1'b0;
            if (win_term)
                rpm_q <= rpm_d;

            if (ign_any) begin
                if (have_ign_q) begin
                    period_q       <= per_cnt_q;
                    period_valid_q <= 1'b1;
                end
                have_ign_q <= 1'b1;
            end
            if (state_q != TRACK)
                have_ign_q <= 1'b0;

            case (state_q)
                SEARCH: begin
                    if (bus.sample_en) begin
                        prev1_q      <= bus.cil1;
                        prev2_q      <= bus.cil2;
                        prev_valid_q <= 1'b1;
                        if (prev_valid_q && good) begin
                            if (good_cnt_q == GW'(LOCK_COUNT - 1)) begin
                                state_q    <= TRACK;
                                locked_q   <= 1'b1;
                                good_cnt_q <= '0;
                            end else begin
                                good_cnt_q <= good_cnt_q + 1'b1;
                            end
                        end else begin
                            good_cnt_q <= '0;
                        end
                    end
                end
                TRACK: begin
                    if (bus.sample_en) begin
                        if (good) begin
                            prev1_q <= bus.cil1;
                            prev2_q <= bus.cil2;
                        end else begin
                            state_q      <= FAULT;
                            locked_q     <= 1'b0;
                            prev_valid_q <= 1'b0;
                        end
                    end
                end
                FAULT: begin
                    state_q      <= SEARCH;
                    prev_valid_q <= 1'b0;
                    good_cnt_q   <= '0;
                end
                default: begin
                    state_q      <= SEARCH;
                    locked_q     <= 1'b0;
                    prev_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.locked        = locked_q;
    assign bus.ign_pulse     = ign_pulse_q;
    assign bus.ign_count     = ign_count_q;
    assign bus.period_cycles = period_q;
    assign bus.period_valid  = period_valid_q;
    assign bus.rpm_est       = rpm_q;
    assign bus.seq_err1      = seq_err1_q;
    assign bus.seq_err2      = seq_err2_q;
    assign bus.phase_err     = phase_err_q;
    assign bus.err_count     = err_count_q;
endmodule

// File: tb/tb_motor_monitor.sv
// tb/tb_motor_monitor.sv - scoreboard bench for motor_monitor
// Driver pushes expected ignition results; a negedge monitor pops and compares on each ign_pulse.
module tb_motor_monitor;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    motor_monitor_if bus1 ();
    motor_monitor_if bus2 ();

    motor_monitor dut1 (.clk(clk), .reset(reset), .bus(bus1));
    motor_monitor #(.RPM_PER_IGN(20)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    typedef struct {
        logic [15:0] cnt;
        logic        pv;
        logic [15:0] per;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   exp_cnt = 0;
    bit   have_ign = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit en, input logic [3:0] c1, input logic [3:0] c2, input bit clr);
        bus1.sample_en = en; bus1.cil1 = c1; bus1.cil2 = c2; bus1.clr_err = clr;
        bus2.sample_en = en; bus2.cil1 = c1; bus2.cil2 = c2; bus2.clr_err = clr;
        @(posedge clk);
        #1;
    endtask

    // Legal stream from an empty slot: lock at index 4, ignitions on even indices after that.
    task automatic run_legal(input int start, input int n);
        logic [3:0] c1, c2;
        for (int k = start; k < start + n; k++) begin
            c1 = 4'b1000 >> (k % 4);
            c2 = {c1[1:0], c1[3:2]};
            if (k > 4 && (k % 2) == 0) begin
                exp_cnt++;
                sb.push_back('{16'(exp_cnt), have_ign, 16'd2});
                have_ign = 1'b1;
            end
            drive(1'b1, c1, c2, 1'b0);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_locked"},    bus1.locked,        0);
        chk({tag, "_ign_pulse"}, bus1.ign_pulse,     0);
        chk({tag, "_ign_count"}, bus1.ign_count,     0);
        chk({tag, "_period"},    bus1.period_cycles, 0);
        chk({tag, "_pvalid"},    bus1.period_valid,  0);
        chk({tag, "_rpm"},       bus1.rpm_est,       0);
        chk({tag, "_rpm20"},     bus2.rpm_est,       0);
        chk({tag, "_errs"},      {bus1.seq_err1, bus1.seq_err2, bus1.phase_err}, 0);
        chk({tag, "_err_count"}, bus1.err_count,     0);
    endtask

    always @(negedge clk) begin
        if (bus1.period_valid && !bus1.ign_pulse) begin
            tests++;
            fails++;
            $display("FAIL period_valid_alone: got 1 expected 0");
        end
        if (bus1.ign_pulse) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ign: got ign_pulse=1 expected 0 (count %0d)", bus1.ign_count);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_ign_count", bus1.ign_count, mon_e.cnt);
                chk("sb_period_valid", bus1.period_valid, mon_e.pv);
                if (mon_e.pv)
                    chk("sb_period_cycles", bus1.period_cycles, mon_e.per);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drive(1'b1, 4'b1000, 4'b0010, 1'b1);
        drive(1'b0, 4'b0100, 4'b0001, 1'b0);
        drive(1'b1, 4'b0110, 4'b1111, 1'b1);
        chk_zero("reset");

        reset = 1'b0;
        for (int i = 0; i < 3; i++)
            drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        chk_zero("idle");

        run_legal(0, 4);
        chk("locked_after_4", bus1.locked, 0);
        run_legal(4, 1);
        chk("locked_after_5", bus1.locked, 1);
        run_legal(5, 3097);
        chk("rpm_steady", bus1.rpm_est, 3000);
        chk("rpm20_sat", bus2.rpm_est, 8191);
        chk("clean_errs", {bus1.seq_err1, bus1.seq_err2, bus1.phase_err, bus1.err_count}, 0);

        // cil1 0100 -> 0001 while cil2 advances legally 0001 -> 1000
        drive(1'b1, 4'b0001, 4'b1000, 1'b0);
        have_ign = 1'b0;
        chk("e1_locked", bus1.locked, 0);
        chk("e1_seq_err1", bus1.seq_err1, 1);
        chk("e1_seq_err2", bus1.seq_err2, 0);
        chk("e1_phase_err", bus1.phase_err, 1);
        chk("e1_err_count", bus1.err_count, 1);

        drive(1'b1, 4'b1000, 4'b0010, 1'b0);
        run_legal(0, 4);
        chk("relock_early", bus1.locked, 0);
        run_legal(4, 1);
        chk("relock", bus1.locked, 1);
        chk("e1_sticky", bus1.seq_err1, 1);
        run_legal(5, 7);

        // 1000/1000 after 0001/0100 with simultaneous clr_err
        drive(1'b1, 4'b1000, 4'b1000, 1'b1);
        have_ign = 1'b0;
        chk("e2_locked", bus1.locked, 0);
        chk("e2_seq_err1", bus1.seq_err1, 0);
        chk("e2_seq_err2", bus1.seq_err2, 1);
        chk("e2_phase_err", bus1.phase_err, 1);
        chk("e2_err_count", bus1.err_count, 1);

        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        drive(1'b1, 4'b1000, 4'b0010, 1'b0);
        drive(1'b1, 4'b0100, 4'b0110, 1'b0);
        chk("search_seq_err1", bus1.seq_err1, 0);
        chk("search_err_count", bus1.err_count, 1);

        drive(1'b0, 4'b0000, 4'b0000, 1'b1);
        chk("clr_errs", {bus1.seq_err1, bus1.seq_err2, bus1.phase_err}, 0);
        chk("clr_err_count", bus1.err_count, 0);
        chk("pre_reset_rpm", bus1.rpm_est, 3000);
        chk("pre_reset_rpm20", bus2.rpm_est, 8191);

        reset = 1'b1;
        drive(1'b1, 4'b0010, 4'b1000, 1'b1);
        chk_zero("mid_reset");
        reset = 1'b0;
        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        chk("post_reset_locked", bus1.locked, 0);

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
